prod_accumulator: RTL and testbench

- Downstream consumer of the 4x4 sequential multiplier: takes each `product` qualified by its `op_ready` strobe.
- Sums NUM_TERMS consecutive products into one dot-product result.
- Presents the result on a valid/ready output handshake with a one-entry hold buffer.
- Back-pressure flows upstream via `in_ready`; products offered while `in_ready`=0 are discarded and flagged.

---
 rtl/prod_accumulator_if.sv | 29 ++
 rtl/prod_accumulator.sv | 154 +++++++++++++++
 tb/tb_prod_accumulator.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/prod_accumulator_if.sv
// Product-in / sum-out bundle of the product accumulator.
// slave is the accumulator's view; master is the upstream/downstream environment.
interface prod_accumulator_if #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int NUM_TERMS = 4
) ();
  localparam int TC_W = $clog2(NUM_TERMS + 1);

  logic [PROD_W-1:0] product;
  logic              op_ready;
  logic              in_ready;
  logic              dropped;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              overflow;
  logic [TC_W-1:0]   term_cnt;

  modport slave (
    input  product, op_ready, sum_ready,
    output in_ready, dropped, sum, sum_valid, overflow, term_cnt
  );

  modport master (
    output product, op_ready, sum_ready,
    input  in_ready, dropped, sum, sum_valid, overflow, term_cnt
  );
endinterface

// File: rtl/prod_accumulator.sv
// Sums NUM_TERMS products into one result held on a valid/ready output.
// Define ACC_SAT_EN to saturate the accumulator instead of wrapping.
module prod_accumulator #(
  parameter int PROD_W    = 8,
  parameter int ACC_W     = 12,
  parameter int NUM_TERMS = 4
) (
  input  logic                clk,
  input  logic                rst,
  prod_accumulator_if.slave   bus
);
  localparam int TC_W = $clog2(NUM_TERMS + 1);
  localparam logic [TC_W-1:0] LAST_CNT = TC_W'(NUM_TERMS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [ACC_W:0] add_term(input logic [ACC_W-1:0] base,
                                              input logic [PROD_W-1:0] p);
    return {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, p};
  endfunction

  state_e            state_r, state_next_s;
  logic [ACC_W-1:0]  acc_r, acc_next_s;
  logic              acc_ovf_r, acc_ovf_next_s;
  logic [TC_W-1:0]   term_cnt_r, term_cnt_next_s;
  logic [ACC_W-1:0]  sum_r, sum_next_s;
  logic              overflow_r, overflow_next_s;
  logic              sum_valid_r, sum_valid_next_s;
  logic              dropped_r, dropped_next_s;

  logic              in_ready_s;
  logic              accept_s;
  logic              handshake_s;
  logic              last_s;
  logic [ACC_W-1:0]  base_acc_s;
  logic              base_ovf_s;
  logic [ACC_W:0]    add_s;
  logic [ACC_W-1:0]  new_acc_s;
  logic              new_ovf_s;

  assign in_ready_s  = (state_r != HOLD) | bus.sum_ready;
  assign accept_s    = bus.op_ready & in_ready_s;
  assign handshake_s = (state_r == HOLD) & bus.sum_ready;
  assign last_s      = (term_cnt_r == LAST_CNT);

  // Term arithmetic: a new block starts from zero with a clear carry history
  always_comb begin
    base_acc_s = acc_r;
    base_ovf_s = acc_ovf_r;
    if (term_cnt_r == {TC_W{1'b0}}) begin
      base_acc_s = {ACC_W{1'b0}};
      base_ovf_s = 1'b0;
    end else begin
      base_acc_s = acc_r;
      base_ovf_s = acc_ovf_r;
    end
    add_s     = add_term(base_acc_s, bus.product);
    new_ovf_s = base_ovf_s | add_s[ACC_W];
`ifdef ACC_SAT_EN
    if (new_ovf_s) begin
      new_acc_s = {ACC_W{1'b1}};
    end else begin
      new_acc_s = add_s[ACC_W-1:0];
    end
`else
    new_acc_s = add_s[ACC_W-1:0];
`endif
  end

  // Next-state, datapath and output-register decode
  always_comb begin
    state_next_s    = state_r;
    acc_next_s      = acc_r;
    acc_ovf_next_s  = acc_ovf_r;
    term_cnt_next_s = term_cnt_r;
    sum_next_s      = sum_r;
    overflow_next_s = overflow_r;
    dropped_next_s  = bus.op_ready & ~in_ready_s;

    case (state_r)
      IDLE, ACCUM: begin
        if (accept_s) begin
          state_next_s = last_s ? HOLD : ACCUM;
        end else begin
          state_next_s = state_r;
        end
      end
      HOLD: begin
        if (handshake_s && accept_s) begin
          state_next_s = last_s ? HOLD : ACCUM;
        end else if (handshake_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    if (accept_s) begin
      acc_next_s     = new_acc_s;
      acc_ovf_next_s = new_ovf_s;
      if (last_s) begin
        term_cnt_next_s = {TC_W{1'b0}};
        sum_next_s      = new_acc_s;
        overflow_next_s = new_ovf_s;
      end else begin
        term_cnt_next_s = term_cnt_r + TC_W'(1);
      end
    end else begin
      acc_next_s      = acc_r;
      acc_ovf_next_s  = acc_ovf_r;
      term_cnt_next_s = term_cnt_r;
    end

    sum_valid_next_s = (state_next_s == HOLD);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      acc_r       <= {ACC_W{1'b0}};
      acc_ovf_r   <= 1'b0;
      term_cnt_r  <= {TC_W{1'b0}};
      sum_r       <= {ACC_W{1'b0}};
      overflow_r  <= 1'b0;
      sum_valid_r <= 1'b0;
      dropped_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      acc_r       <= acc_next_s;
      acc_ovf_r   <= acc_ovf_next_s;
      term_cnt_r  <= term_cnt_next_s;
      sum_r       <= sum_next_s;
      overflow_r  <= overflow_next_s;
      sum_valid_r <= sum_valid_next_s;
      dropped_r   <= dropped_next_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.dropped   = dropped_r;
  assign bus.sum       = sum_r;
  assign bus.sum_valid = sum_valid_r;
  assign bus.overflow  = overflow_r;
  assign bus.term_cnt  = term_cnt_r;
endmodule

// File: tb/tb_prod_accumulator.sv
// Scoreboard bench for prod_accumulator: default instance plus a 9-bit accumulator instance.
module tb_prod_accumulator;
  logic clk;
  logic rst;

  prod_accumulator_if #(.PROD_W(8), .ACC_W(12), .NUM_TERMS(4)) a ();
  prod_accumulator_if #(.PROD_W(8), .ACC_W(9),  .NUM_TERMS(4)) b ();

  prod_accumulator #(.PROD_W(8), .ACC_W(12), .NUM_TERMS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  prod_accumulator #(.PROD_W(8), .ACC_W(9), .NUM_TERMS(4)) dut9 (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  typedef struct {
    int sum;
    bit ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_sum(input int w, input int p0, input int p1, input int p2, input int p3);
    int total;
    int lim;
    total = p0 + p1 + p2 + p3;
    lim   = 1 << w;
`ifdef ACC_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  function automatic bit model_ovf(input int w, input int p0, input int p1, input int p2, input int p3);
    return (p0 + p1 + p2 + p3) >= (1 << w);
  endfunction

  function automatic void push_exp(input int w, input int p0, input int p1, input int p2, input int p3);
    exp_t e;
    e.sum = model_sum(w, p0, p1, p2, p3);
    e.ovf = model_ovf(w, p0, p1, p2, p3);
    exp_q.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p);
    a.product  = 8'(p);
    a.op_ready = 1'b1;
    tick();
    a.op_ready = 1'b0;
  endtask

  // Output monitor: every completed handshake is scored against the queue
  always @(negedge clk) begin
    if (rst && a.sum_valid && a.sum_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_sum", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sb_sum", 32'(a.sum), 32'(e.sum));
        check_eq("sb_overflow", 32'(a.overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    rst         = 1'b0;
    a.product   = 8'd0;
    a.op_ready  = 1'b0;
    a.sum_ready = 1'b1;
    b.product   = 8'd0;
    b.op_ready  = 1'b0;
    b.sum_ready = 1'b1;

    // Reset state
    #3;
    check_eq("rst_sum", 32'(a.sum), 32'd0);
    check_eq("rst_sum_valid", 32'(a.sum_valid), 32'd0);
    check_eq("rst_overflow", 32'(a.overflow), 32'd0);
    check_eq("rst_dropped", 32'(a.dropped), 32'd0);
    check_eq("rst_term_cnt", 32'(a.term_cnt), 32'd0);
    check_eq("rst_in_ready", 32'(a.in_ready), 32'd1);
    #9;
    rst = 1'b1;
    tick();

    // Basic block with downstream always ready
    push_exp(12, 10, 20, 30, 40);
    send(10);
    send(20);
    send(30);
    check_eq("t1_cnt3", 32'(a.term_cnt), 32'd3);
    check_eq("t1_valid_early", 32'(a.sum_valid), 32'd0);
    send(40);
    check_eq("t1_valid", 32'(a.sum_valid), 32'd1);
    check_eq("t1_sum", 32'(a.sum), 32'd100);
    check_eq("t1_cnt0", 32'(a.term_cnt), 32'd0);
    tick();
    check_eq("t1_valid_low", 32'(a.sum_valid), 32'd0);

    // Back-pressure: held result, dropped product, then release
    a.sum_ready = 1'b0;
    push_exp(12, 255, 255, 255, 255);
    for (int i = 0; i < 4; i++) send(255);
    check_eq("t2_valid", 32'(a.sum_valid), 32'd1);
    check_eq("t2_sum", 32'(a.sum), 32'd1020);
    check_eq("t2_in_ready", 32'(a.in_ready), 32'd0);
    send(9);
    check_eq("t2_dropped", 32'(a.dropped), 32'd1);
    check_eq("t2_sum_held", 32'(a.sum), 32'd1020);
    check_eq("t2_cnt_held", 32'(a.term_cnt), 32'd0);
    tick();
    check_eq("t2_dropped_pulse", 32'(a.dropped), 32'd0);
    check_eq("t2_still_valid", 32'(a.sum_valid), 32'd1);
    a.sum_ready = 1'b1;
    #1;
    check_eq("t2_in_ready_comb", 32'(a.in_ready), 32'd1);
    tick();
    check_eq("t2_valid_low", 32'(a.sum_valid), 32'd0);

    // Handshake and new first term in the same cycle
    a.sum_ready = 1'b0;
    push_exp(12, 1, 2, 3, 4);
    push_exp(12, 7, 1, 1, 1);
    send(1);
    send(2);
    send(3);
    send(4);
    check_eq("t3_hold", 32'(a.sum_valid), 32'd1);
    a.sum_ready = 1'b1;
    send(7);
    check_eq("t3_cnt1", 32'(a.term_cnt), 32'd1);
    check_eq("t3_valid_low", 32'(a.sum_valid), 32'd0);
    send(1);
    send(1);
    send(1);
    check_eq("t3_sum", 32'(a.sum), 32'd10);
    check_eq("t3_valid", 32'(a.sum_valid), 32'd1);
    tick();

    // Asynchronous reset in the middle of a block
    send(5);
    send(6);
    check_eq("t4_cnt2", 32'(a.term_cnt), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t4_async_valid", 32'(a.sum_valid), 32'd0);
    check_eq("t4_async_cnt", 32'(a.term_cnt), 32'd0);
    check_eq("t4_async_sum", 32'(a.sum), 32'd0);
    #3;
    rst = 1'b1;
    tick();
    push_exp(12, 1, 2, 3, 4);
    send(1);
    send(2);
    send(3);
    send(4);
    check_eq("t4_sum", 32'(a.sum), 32'd10);
    tick();

    // Idle gaps between products never cause drops
    push_exp(12, 10, 20, 30, 40);
    for (int i = 0; i < 4; i++) begin
      send(10 * (i + 1));
      check_eq("t5_no_drop", 32'(a.dropped), 32'd0);
      for (int g = 0; g < i; g++) begin
        tick();
        check_eq("t5_gap_cnt", 32'(a.term_cnt), 32'((i + 1) % 4));
        check_eq("t5_gap_no_drop", 32'(a.dropped), 32'd0);
      end
    end
    tick();
    check_eq("t5_no_drop_end", 32'(a.dropped), 32'd0);

    // Narrow accumulator: wrap or saturate with sticky overflow
    for (int i = 0; i < 4; i++) begin
      b.product  = 8'd255;
      b.op_ready = 1'b1;
      tick();
    end
    b.op_ready = 1'b0;
    check_eq("t6_valid", 32'(b.sum_valid), 32'd1);
    check_eq("t6_sum", 32'(b.sum), 32'(model_sum(9, 255, 255, 255, 255)));
    check_eq("t6_overflow", 32'(b.overflow), 32'(model_ovf(9, 255, 255, 255, 255)));
    tick();
    check_eq("t6_valid_low", 32'(b.sum_valid), 32'd0);

    tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
